rom_stream_reader: RTL and testbench
====================================

Name: rom_stream_reader

Overview:
Read sequencer that sits directly upstream of the single-port ROM and drives its en/addr pins. It walks a programmable address window and absorbs the ROM's 1-cycle registered read latency. Returned words are presented downstream as a valid/ready stream with a last marker. A 2-entry skid buffer provides full-throughput backpressure with no loss or duplication.

Parameters:
ADDR_W, 3, ROM address width
DATA_W, 4, ROM word width
DEPTH, 8, ROM word count (= 2**ADDR_W); addresses wrap modulo DEPTH

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  burst request; sampled only in IDLE
start_addr  in  ADDR_W  first ROM address of the burst
count  in  ADDR_W+1  words in the burst; 0 means DEPTH
busy  out  1  high from the cycle after start is accepted until done
done  out  1  1-cycle pulse on the handshake of the final word
rom_en  out  1  ROM read enable, high only on issue cycles
rom_addr  out  ADDR_W  ROM address
rom_data  in  DATA_W  ROM registered read data, valid 1 cycle after rom_en
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_data  out  DATA_W  stream data
out_last  out  1  high with the final word of the burst

Behaviour:
- Reset (asynchronous, any state): FSM=IDLE, FIFO flushed, in-flight flag cleared. busy, done, rom_en, out_valid and out_last are 0; rom_addr and out_data are 0.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE when start=1. Latch start_addr and remaining count (0 -> DEPTH).
  - ISSUE -> DRAIN after the last read is issued.
  - DRAIN -> IDLE on the handshake of the word with out_last.
- start is ignored while busy=1, including in the cycle done pulses. It is accepted on the following cycle.
- Issue rule: in ISSUE, assert rom_en with the current rom_addr when fifo_count + inflight - pop < 2 (pop = out_valid & out_ready this cycle).
  - On each issue, rom_addr increments modulo DEPTH (7 -> 0) and remaining decrements.
  - rom_addr holds its value on non-issue cycles.
- Capture: inflight=1 in the cycle after an issue; rom_data is pushed into the FIFO at that edge together with its last flag.
- Latency: start sampled at edge T; first rom_en in cycle T+1; first out_valid in cycle T+3.
- Throughput: with out_ready held high, one word per cycle, so an 8-word burst shows out_valid for 8 consecutive cycles.
- FIFO: 2 entries, registered outputs. out_data and out_last are stable while out_valid=1 and out_ready=0. Simultaneous push and pop are allowed at any occupancy of 1 or more.
- Never push to a full FIFO; the issue rule guarantees this. An assertion checks it.
- done pulses in the cycle after the final handshake, when busy also drops.

Optional Feature:
Macro: ROM_STREAM_CSUM_EN
- Defined: adds output port csum (DATA_W). It holds the XOR of all words delivered in the current burst. It clears on start acceptance and is final and stable when done pulses, until the next start.
- Undefined: csum port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package rom_pkg holds:
  - ADDR_W, DATA_W and DEPTH constants.
  - The FSM state typedef (IDLE/ISSUE/DRAIN).
  - The shared ROM content table used by benches as the golden model.
- Sub-module rom_skid_fifo: 2-entry FIFO carrying {last, data}, with push, pop, count and the valid/ready interface.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately; rom_en=0 until a new start.
- Full burst: start_addr=0, count=0, out_ready=1 -> out_data 1,3,A,6,7,D,9,B on 8 consecutive cycles; out_last on B; done 1 cycle later; csum=0x6.
- Wrap: start_addr=6, count=4 -> 9,B,1,3; rom_addr sequence 6,7,0,1; csum=0x0.
- Backpressure: full burst with out_ready random 50% -> exactly 8 words in order; no FIFO overflow; data held stable while stalled.
- Start while busy: pulse start at cycle 3 of a burst with start_addr=5 -> ignored, original burst completes. A start in the done cycle is ignored; a start in the following cycle is accepted.
- Reset mid-burst: rst after 3 words delivered -> out_valid=0, busy=0. A new start with start_addr=2, count=1 -> single word A with out_last.

Source files
------------

// File: rtl/rom_pkg.sv
// rtl/rom_pkg.sv - shared constants, FSM state type and ROM content table
package rom_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Contents of the ROM sitting downstream of rom_addr; benches model the ROM with it.
  localparam logic [DATA_W-1:0] ROM_TABLE [DEPTH] = '{
    4'h1, 4'h3, 4'hA, 4'h6, 4'h7, 4'hD, 4'h9, 4'hB
  };

endpackage

// File: rtl/rom_skid_fifo.sv
// rtl/rom_skid_fifo.sv - 2-entry FIFO with registered head, carrying {last, data}
module rom_skid_fifo #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         valid
);

  logic [W-1:0] tail;

  assign valid = (count != 2'd0);

  // Head is the oldest word and drives the stream directly; tail holds the second word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      if (push && pop) begin
        if (count == 2'd1) begin
          head <= din;
        end else begin
          head <= tail;
          tail <= din;
        end
      end else if (push) begin
        if (count == 2'd0) head <= din;
        else               tail <= din;
        count <= count + 2'd1;
      end else if (pop) begin
        if (count == 2'd2) head <= tail;
        count <= count - 2'd1;
      end
    end
  end

  // The reader's issue throttle must never let a word arrive with no room for it.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == 2'd2));

endmodule

// File: rtl/rom_stream_reader.sv
// rtl/rom_stream_reader.sv - ROM burst reader with valid/ready output; optional csum via ROM_STREAM_CSUM_EN
module rom_stream_reader
  import rom_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
`ifdef ROM_STREAM_CSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   remaining;
  logic              inflight, inflight_last;
  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic [2:0]        occupancy;
  logic              pop, issue, last_issue, accept;

  assign pop        = out_valid && out_ready;
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == ISSUE) && (occupancy < 3'd2);
  assign last_issue = issue && (remaining == (ADDR_W+1)'(1));
  assign accept     = (state == IDLE) && start && !done;
  assign rom_en     = issue;
  assign busy       = (state != IDLE);
  assign out_data   = fifo_head[DATA_W-1:0];
  assign out_last   = fifo_head[DATA_W];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: issue phase ends with the final read, drain ends on the last handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (pop && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address walk, remaining count, one-deep read-latency tracker and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr      <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= (state == DRAIN) && pop && out_last;
      inflight      <= issue;
      inflight_last <= last_issue;
      if (accept) begin
        rom_addr  <= start_addr;
        remaining <= (count == '0) ? (ADDR_W+1)'(DEPTH) : count;
      end else if (issue) begin
        rom_addr  <= rom_addr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W+1)'(1);
      end
    end
  end

  rom_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   ({inflight_last, rom_data}),
    .pop   (pop),
    .head  (fifo_head),
    .count (fifo_count),
    .valid (out_valid)
  );

`ifdef ROM_STREAM_CSUM_EN
  // Running XOR of delivered words, restarted when a burst is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         csum <= '0;
    else if (accept) csum <= '0;
    else if (pop)    csum <= csum ^ out_data;
  end
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb/tb_rom_stream_reader.sv - directed self-checking bench for rom_stream_reader
module tb_rom_stream_reader;
  import rom_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W:0]   count = '0;
  logic              busy, done, rom_en, out_valid, out_last;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
`ifdef ROM_STREAM_CSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  rom_stream_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
`ifdef ROM_STREAM_CSUM_EN
    ,
    .csum       (csum)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int errors = 0;
  int cyc = 0;
  int done_at = 0;
  bit rand_ready = 1'b0;
  bit ready_fixed = 1'b1;

  logic [3:0]        got_data [$];
  logic              got_last [$];
  logic [ADDR_W-1:0] got_addr [$];
  int                hs_cyc   [$];
  bit                prev_stall = 1'b0;
  logic [4:0]        prev_word = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // ROM with one cycle registered read latency.
  always @(posedge clk) if (rom_en) rom_data <= ROM_TABLE[rom_addr];

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  // Stream monitor: record handshakes and issued addresses, check hold-while-stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (rom_en) got_addr.push_back(rom_addr);
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        hs_cyc.push_back(cyc);
      end
      if (prev_stall) check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_word});
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end
  end

  task automatic clear_mon();
    got_data.delete();
    got_last.delete();
    got_addr.delete();
    hs_cyc.delete();
  endtask

  task automatic start_burst(input logic [ADDR_W-1:0] sa, input logic [ADDR_W:0] cnt);
    @(posedge clk); #1;
    start = 1'b1; start_addr = sa; count = cnt;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (done) begin
        seen = 1'b1;
        done_at = cyc;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_stream(input string tag, input logic [3:0] exp [$]);
    check({tag, "_len"}, got_data.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_data.size(); i++) begin
      check($sformatf("%s_d%0d", tag, i), 32'(got_data[i]), 32'(exp[i]));
      check($sformatf("%s_l%0d", tag, i), 32'(got_last[i]), 32'(i == exp.size() - 1));
    end
  endtask

  logic [3:0]        e_full [$] = '{4'h1, 4'h3, 4'hA, 4'h6, 4'h7, 4'hD, 4'h9, 4'hB};
  logic [3:0]        e_wrap [$] = '{4'h9, 4'hB, 4'h1, 4'h3};
  logic [3:0]        e_five [$] = '{4'hD};
  logic [3:0]        e_two  [$] = '{4'hA};
  logic [ADDR_W-1:0] a_wrap [$] = '{3'd6, 3'd7, 3'd0, 3'd1};

  initial begin
    // Reset asserted between edges must clear everything immediately.
    #1 rst = 1'b1;
    #1;
    check("rst_outputs", {busy, done, rom_en, out_valid, out_last, rom_addr, out_data},
          '0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Full burst with latency and throughput checks.
    clear_mon();
    start_burst(3'd0, 4'd0);
    check("lat_rom_en_t1", {busy, rom_en, out_valid, rom_addr}, {1'b1, 1'b1, 1'b0, 3'd0});
    @(posedge clk); #1;
    check("lat_no_valid_t2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid_t3", 32'(out_valid), 32'd1);
    wait_done("full", 40);
    check_stream("full", e_full);
    if (hs_cyc.size() == 8) begin
      check("full_back_to_back", hs_cyc[7] - hs_cyc[0], 7);
      check("full_done_latency", done_at - hs_cyc[7], 1);
    end
`ifdef ROM_STREAM_CSUM_EN
    check("full_csum", 32'(csum), 32'h6);
`endif

    // Wrap-around window.
    clear_mon();
    start_burst(3'd6, 4'd4);
    wait_done("wrap", 40);
    check_stream("wrap", e_wrap);
    check("wrap_addr_len", got_addr.size(), 4);
    for (int i = 0; i < 4 && i < got_addr.size(); i++)
      check($sformatf("wrap_addr%0d", i), 32'(got_addr[i]), 32'(a_wrap[i]));
`ifdef ROM_STREAM_CSUM_EN
    check("wrap_csum", 32'(csum), 32'h0);
`endif

    // Random backpressure on a full burst.
    clear_mon();
    rand_ready = 1'b1;
    start_burst(3'd0, 4'd0);
    wait_done("bp", 300);
    rand_ready = 1'b0;
    check_stream("bp", e_full);
`ifdef ROM_STREAM_CSUM_EN
    check("bp_csum", 32'(csum), 32'h6);
`endif

    // Start while busy, in the done cycle, and one cycle later.
    clear_mon();
    start_burst(3'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; start_addr = 3'd5; count = 4'd1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("busy_start", 40);
    check_stream("busy_start", e_five.size() == 0 ? e_full : e_full);
    clear_mon();
    start = 1'b1; start_addr = 3'd5; count = 4'd1;
    @(posedge clk); #1;
    check("start_in_done_ignored", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("start_after_done_taken", {busy, rom_en, rom_addr}, {1'b1, 1'b1, 3'd5});
    start = 1'b0;
    wait_done("after_done", 40);
    check_stream("after_done", e_five);

    // Reset in the middle of a burst, then a single-word burst.
    clear_mon();
    start_burst(3'd0, 4'd0);
    for (int i = 0; i < 40 && got_data.size() < 3; i++) begin
      @(negedge clk); #1;
    end
    check("mid_three_words", 32'(got_data.size() >= 3), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_outputs", {busy, done, rom_en, out_valid, out_last, rom_addr, out_data},
          '0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("mid_idle_rom_en%0d", i), {rom_en, busy}, 2'b00);
    end
    clear_mon();
    start_burst(3'd2, 4'd1);
    wait_done("single", 40);
    check_stream("single", e_two);
`ifdef ROM_STREAM_CSUM_EN
    check("single_csum", 32'(csum), 32'hA);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
